// File: rtl/mycpu_pkg.sv
// Shared constants for the execute stage: bus widths, stage 2->3 field offsets,
// ALU op bit positions, divider state encoding and a magnitude helper.
package mycpu_pkg;

    localparam int unsigned S2TO3_W = 151;
    localparam int unsigned S3TO4_W = 39;

    // Field LSB offsets in stage_2_to_3, MSB-first order
    localparam int unsigned OFF_ALU_OP       = 139;
    localparam int unsigned OFF_DIV_EN       = 138;
    localparam int unsigned OFF_DIV_SIGNED   = 137;
    localparam int unsigned OFF_DIV_REM      = 136;
    localparam int unsigned OFF_SRC1         = 104;
    localparam int unsigned OFF_SRC2         = 72;
    localparam int unsigned OFF_RKD          = 40;
    localparam int unsigned OFF_MEM_WE       = 39;
    localparam int unsigned OFF_RES_FROM_MEM = 38;
    localparam int unsigned OFF_RF_WE        = 37;
    localparam int unsigned OFF_DEST         = 32;
    localparam int unsigned OFF_PC           = 0;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/stage_3_ex_if.sv
// Stage 2/3/4 handshake, payload buses and data-SRAM request of the execute stage.
interface stage_3_ex_if;
    import mycpu_pkg::*;

    logic               valid_2;
    logic               allow_3;
    logic [S2TO3_W-1:0] stage_2_to_3;
    logic               valid_3;
    logic               allow_4;
    logic [S3TO4_W-1:0] stage_3_to_4;
    logic [31:0]        alu_result;
    logic [4:0]         rf_waddr_3_fwd;
    logic               load_3_fwd;
    logic               data_sram_en;
    logic [3:0]         data_sram_we;
    logic [31:0]        data_sram_addr;
    logic [31:0]        data_sram_wdata;

    modport slave (
        input  valid_2, stage_2_to_3, allow_4,
        output allow_3, valid_3, stage_3_to_4, alu_result, rf_waddr_3_fwd, load_3_fwd,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport master (
        output valid_2, stage_2_to_3, allow_4,
        input  allow_3, valid_3, stage_3_to_4, alu_result, rf_waddr_3_fwd, load_3_fwd,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU with one-hot operation select.
import mycpu_pkg::*;

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic        use_sub;
    logic [31:0] adder_b;
    logic [31:0] sum;
    logic        cout;
    logic        slt;
    logic        sltu;
    logic [31:0] sra_res;

    // add/sub/slt/sltu share one adder computing src1 + ~src2 + 1 for compares
    assign use_sub       = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
    assign adder_b       = use_sub ? ~alu_src2 : alu_src2;
    assign {cout, sum}   = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};
    assign slt           = (alu_src1[31] & ~alu_src2[31]) |
                           (~(alu_src1[31] ^ alu_src2[31]) & sum[31]);
    assign sltu          = ~cout;
    assign sra_res       = $signed(alu_src1) >>> alu_src2[4:0];

    assign alu_result =
          ({32{alu_op[ALU_ADD] | alu_op[ALU_SUB]}} & sum)
        | ({32{alu_op[ALU_SLT]}}  & {31'd0, slt})
        | ({32{alu_op[ALU_SLTU]}} & {31'd0, sltu})
        | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
        | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
        | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
        | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
        | ({32{alu_op[ALU_SLL]}}  & (alu_src1 << alu_src2[4:0]))
        | ({32{alu_op[ALU_SRL]}}  & (alu_src1 >> alu_src2[4:0]))
        | ({32{alu_op[ALU_SRA]}}  & sra_res)
        | ({32{alu_op[ALU_LUI]}}  & alu_src2);

endmodule

// File: rtl/div_iter.sv
// 32-step restoring divider on operand magnitudes, sign fix applied on the way out.
import mycpu_pkg::*;

module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic        rem,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] result
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] part_rem;
    logic [31:0] quot;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        take;

    // Partial remainder stays below the divisor, so diff[32] is a clean borrow flag
    assign trial = {part_rem, quot[31]};
    assign diff  = trial - {1'b0, dvs};
    assign take  = ~diff[32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            part_rem <= '0;
            quot     <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state    <= DIV_BUSY;
                        cnt      <= '0;
                        part_rem <= '0;
                        quot     <= mag32(dividend, is_signed);
                        dvs      <= mag32(divisor, is_signed);
                        // divide-by-zero keeps the all-ones quotient unsigned
                        q_neg    <= is_signed & (dividend[31] ^ divisor[31]) & (|divisor);
                        r_neg    <= is_signed & dividend[31];
                    end
                end
                DIV_BUSY: begin
                    part_rem <= take ? diff[31:0] : trial[31:0];
                    quot     <= {quot[30:0], take};
                    cnt      <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign done   = (state == DIV_DONE);
    assign result = rem ? (r_neg ? (32'd0 - part_rem) : part_rem)
                        : (q_neg ? (32'd0 - quot) : quot);

endmodule

// File: rtl/stage_3_ex.sv
// Execute stage: payload register, ALU / divider result mux and data-SRAM request.
// Define MYCPU_DIV_EN to build in the iterative divider.
import mycpu_pkg::*;

module stage_3_ex (
    input  logic         clk,
    input  logic         resetn,
    stage_3_ex_if.slave  bus
);

    logic [S2TO3_W-1:0] in_reg;
    logic               valid_reg;
    logic               readygo_3;
    logic [31:0]        alu_out;
    logic [31:0]        exe_result;

    logic [11:0] alu_op;
    logic        div_en;
    logic        div_signed;
    logic        div_rem;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;

    assign alu_op       = in_reg[OFF_ALU_OP +: 12];
    assign div_en       = in_reg[OFF_DIV_EN];
    assign div_signed   = in_reg[OFF_DIV_SIGNED];
    assign div_rem      = in_reg[OFF_DIV_REM];
    assign src1         = in_reg[OFF_SRC1 +: 32];
    assign src2         = in_reg[OFF_SRC2 +: 32];
    assign rkd_value    = in_reg[OFF_RKD +: 32];
    assign mem_we       = in_reg[OFF_MEM_WE];
    assign res_from_mem = in_reg[OFF_RES_FROM_MEM];
    assign rf_we        = in_reg[OFF_RF_WE];
    assign dest         = in_reg[OFF_DEST +: 5];
    assign pc           = in_reg[OFF_PC +: 32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= 1'b0;
            in_reg    <= '0;
        end else if (bus.allow_3) begin
            valid_reg <= bus.valid_2;
            if (bus.valid_2) begin
                in_reg <= bus.stage_2_to_3;
            end
        end
    end

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_out)
    );

`ifdef MYCPU_DIV_EN
    logic        div_done;
    logic [31:0] div_result;

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (valid_reg & div_en),
        .is_signed (div_signed),
        .rem       (div_rem),
        .dividend  (src1),
        .divisor   (src2),
        .ack       (bus.allow_4),
        .done      (div_done),
        .result    (div_result)
    );

    assign readygo_3  = ~div_en | div_done;
    assign exe_result = div_en ? div_result : alu_out;
`else
    logic unused_div_fields;

    assign unused_div_fields = ^{div_en, div_signed, div_rem};
    assign readygo_3         = 1'b1;
    assign exe_result        = alu_out;
`endif

    assign bus.allow_3        = ~valid_reg | (readygo_3 & bus.allow_4);
    assign bus.valid_3        = valid_reg & readygo_3;
    assign bus.stage_3_to_4   = {rf_we, dest, res_from_mem, pc};
    assign bus.alu_result     = exe_result;
    assign bus.rf_waddr_3_fwd = (valid_reg & rf_we) ? dest : 5'd0;
    assign bus.load_3_fwd     = valid_reg & res_from_mem;

    // Request only in the advancing cycle so a stalled access is never repeated
    assign bus.data_sram_en    = bus.valid_3 & bus.allow_4 & (mem_we | res_from_mem);
    assign bus.data_sram_we    = {4{mem_we & bus.data_sram_en}};
    assign bus.data_sram_addr  = exe_result;
    assign bus.data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_stage_3_ex.sv
// Directed bench for stage_3_ex; divide scenarios run when MYCPU_DIV_EN is defined.
module tb_stage_3_ex;
    import mycpu_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stage_3_ex_if bus ();

    stage_3_ex dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] onehot(input int unsigned idx);
        logic [11:0] v;
        v = 12'd1;
        return v << idx;
    endfunction

    function automatic logic [150:0] mk(input logic [11:0] op, input logic den, input logic dsg,
                                        input logic drm, input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] rkd, input logic mwe, input logic rfm,
                                        input logic rfw, input logic [4:0] dst, input logic [31:0] pc);
        return {op, den, dsg, drm, s1, s2, rkd, mwe, rfm, rfw, dst, pc};
    endfunction

    int unsigned tb_op [12] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_NOR,
                                ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};
    logic [31:0] tb_s1 [12] = '{32'hFFFFFFFF, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                32'h0000FFFF, 32'h12340000, 32'hFFFF0000, 32'd1, 32'h80000000,
                                32'h80000000, 32'd0};
    logic [31:0] tb_s2 [12] = '{32'd1, 32'd3, 32'd1, 32'd1, 32'hFF00FF00, 32'h00FF0000,
                                32'h00005678, 32'h0F0F0F0F, 32'd31, 32'd4, 32'd4, 32'hABCDE000};
    logic [31:0] tb_exp [12] = '{32'd0, 32'd7, 32'd1, 32'd0, 32'hF000F000, 32'hFF000000,
                                 32'h12345678, 32'hF0F00F0F, 32'h80000000, 32'h08000000,
                                 32'hF8000000, 32'hABCDE000};

    task automatic test_reset();
        resetn = 1'b0;
        bus.valid_2 = 1'b0;
        bus.allow_4 = 1'b0;
        bus.stage_2_to_3 = '0;
        #1;
        checks++; if (bus.valid_3 !== 1'b0) begin errors++; $display("FAIL reset_valid_3: got %b want 0", bus.valid_3); end
        checks++; if (bus.allow_3 !== 1'b1) begin errors++; $display("FAIL reset_allow_3: got %b want 1", bus.allow_3); end
        checks++; if (bus.data_sram_en !== 1'b0) begin errors++; $display("FAIL reset_sram_en: got %b want 0", bus.data_sram_en); end
        checks++; if (bus.rf_waddr_3_fwd !== 5'd0) begin errors++; $display("FAIL reset_waddr_fwd: got %0d want 0", bus.rf_waddr_3_fwd); end
        checks++; if (bus.load_3_fwd !== 1'b0) begin errors++; $display("FAIL reset_load_fwd: got %b want 0", bus.load_3_fwd); end
        checks++; if (bus.stage_3_to_4 !== 39'd0) begin errors++; $display("FAIL reset_s3to4: got %h want 0", bus.stage_3_to_4); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        bus.allow_4 = 1'b1;
        bus.stage_2_to_3 = mk(onehot(ALU_ADD), 0, 0, 0, 32'd5, 32'd7, 32'd0, 0, 0, 1, 5'd3, 32'h1C000000);
        bus.valid_2 = 1'b1;
        @(negedge clk);
        bus.valid_2 = 1'b0;
        checks++; if (bus.valid_3 !== 1'b1) begin errors++; $display("FAIL add_valid_3: got %b want 1", bus.valid_3); end
        checks++; if (bus.alu_result !== 32'd12) begin errors++; $display("FAIL add_result: got %h want 0000000c", bus.alu_result); end
        checks++; if (bus.rf_waddr_3_fwd !== 5'd3) begin errors++; $display("FAIL add_waddr_fwd: got %0d want 3", bus.rf_waddr_3_fwd); end
        checks++; if (bus.data_sram_en !== 1'b0) begin errors++; $display("FAIL add_sram_en: got %b want 0", bus.data_sram_en); end
        checks++; if (bus.stage_3_to_4 !== {1'b1, 5'd3, 1'b0, 32'h1C000000}) begin errors++; $display("FAIL add_s3to4: got %h want %h", bus.stage_3_to_4, {1'b1, 5'd3, 1'b0, 32'h1C000000}); end
        @(negedge clk);
        checks++; if (bus.valid_3 !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", bus.valid_3); end
    endtask

    task automatic test_store();
        int n;
        bus.allow_4 = 1'b1;
        bus.stage_2_to_3 = mk(onehot(ALU_ADD), 0, 0, 0, 32'h1000, 32'd8, 32'hDEADBEEF, 1, 0, 0, 5'd0, 32'h1C000004);
        bus.valid_2 = 1'b1;
        @(negedge clk);
        bus.valid_2 = 1'b0;
        checks++; if (bus.data_sram_en !== 1'b1) begin errors++; $display("FAIL store_en: got %b want 1", bus.data_sram_en); end
        checks++; if (bus.data_sram_we !== 4'hF) begin errors++; $display("FAIL store_we: got %h want f", bus.data_sram_we); end
        checks++; if (bus.data_sram_addr !== 32'h1008) begin errors++; $display("FAIL store_addr: got %h want 00001008", bus.data_sram_addr); end
        checks++; if (bus.data_sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h want deadbeef", bus.data_sram_wdata); end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.data_sram_en === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL store_single_issue: got %0d extra requests want 0", n); end
    endtask

    task automatic test_load_stall();
        int bad;
        bus.allow_4 = 1'b0;
        bus.stage_2_to_3 = mk(onehot(ALU_ADD), 0, 0, 0, 32'h2000, 32'd4, 32'd0, 0, 1, 1, 5'd7, 32'h1C000008);
        bus.valid_2 = 1'b1;
        @(negedge clk);
        bus.stage_2_to_3 = mk(onehot(ALU_ADD), 0, 0, 0, 32'd1, 32'd1, 32'd0, 0, 0, 1, 5'd9, 32'h1C00000C);
        checks++; if (bus.valid_3 !== 1'b1) begin errors++; $display("FAIL stall_valid_3: got %b want 1", bus.valid_3); end
        checks++; if (bus.allow_3 !== 1'b0) begin errors++; $display("FAIL stall_allow_3: got %b want 0", bus.allow_3); end
        checks++; if (bus.load_3_fwd !== 1'b1) begin errors++; $display("FAIL stall_load_fwd: got %b want 1", bus.load_3_fwd); end
        checks++; if (bus.rf_waddr_3_fwd !== 5'd7) begin errors++; $display("FAIL stall_waddr_fwd: got %0d want 7", bus.rf_waddr_3_fwd); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.data_sram_en !== 1'b0 || bus.alu_result !== 32'h2004 || bus.valid_3 !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        bus.allow_4 = 1'b1;
        #1;
        checks++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_we !== 4'h0) begin errors++; $display("FAIL load_release: got en=%b we=%h want en=1 we=0", bus.data_sram_en, bus.data_sram_we); end
        @(negedge clk);
        bus.valid_2 = 1'b0;
        checks++; if (bus.alu_result !== 32'd2) begin errors++; $display("FAIL stall_next_result: got %h want 00000002", bus.alu_result); end
        checks++; if (bus.rf_waddr_3_fwd !== 5'd9 || bus.load_3_fwd !== 1'b0) begin errors++; $display("FAIL stall_next_fwd: got %0d/%b want 9/0", bus.rf_waddr_3_fwd, bus.load_3_fwd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.allow_4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.stage_2_to_3 = mk(onehot(tb_op[i]), 0, 0, 0, tb_s1[i], tb_s2[i], 32'd0, 0, 0, 1, 5'd1, 32'h1C000100);
            bus.valid_2 = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.valid_3 !== 1'b1 || bus.alu_result !== tb_exp[i]) begin
                errors++;
                $display("FAIL b2b_op%0d: got valid=%b result=%h want valid=1 result=%h", tb_op[i], bus.valid_3, bus.alu_result, tb_exp[i]);
            end
        end
        bus.valid_2 = 1'b0;
        @(negedge clk);
    endtask

`ifdef MYCPU_DIV_EN
    task automatic run_div(input string name, input logic sg, input logic rm,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int lat;
        int bad_allow;
        bus.stage_2_to_3 = mk(12'd0, 1, sg, rm, a, b, 32'd0, 0, 0, 1, 5'd4, 32'h1C000200);
        bus.valid_2 = 1'b1;
        @(negedge clk);
        bus.valid_2 = 1'b0;
        lat = 0;
        bad_allow = 0;
        while (bus.valid_3 !== 1'b1 && lat < 40) begin
            if (bus.allow_3 !== 1'b0) bad_allow++;
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 33) begin errors++; $display("FAIL %s_latency: got %0d want 33", name, lat); end
        checks++; if (bad_allow !== 0) begin errors++; $display("FAIL %s_allow_busy: got %0d high cycles want 0", name, bad_allow); end
        checks++; if (bus.alu_result !== expv) begin errors++; $display("FAIL %s_result: got %h want %h", name, bus.alu_result, expv); end
    endtask

    task automatic test_div();
        bus.allow_4 = 1'b1;
        run_div("div_w", 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("mod_w", 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("div_wu_zero", 0, 0, 32'd100, 32'd0, 32'hFFFFFFFF);
        run_div("mod_wu_zero", 0, 1, 32'd100, 32'd0, 32'd100);
        run_div("div_w_ovf", 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("mod_w_ovf", 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_div("div_w_zero", 1, 0, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
        run_div("mod_w_zero", 1, 1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
        @(negedge clk);
    endtask

    task automatic test_div_stall();
        int bad;
        bus.allow_4 = 1'b0;
        run_div("div_stall", 0, 0, 32'd20, 32'd6, 32'd3);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.valid_3 !== 1'b1 || bus.alu_result !== 32'd3 || bus.data_sram_en !== 1'b0 || bus.allow_3 !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL div_stall_hold: got %0d bad cycles want 0", bad); end
        bus.allow_4 = 1'b1;
        @(negedge clk);
        checks++; if (bus.valid_3 !== 1'b0) begin errors++; $display("FAIL div_stall_retire: got %b want 0", bus.valid_3); end
    endtask

    task automatic test_div_reset();
        bus.allow_4 = 1'b1;
        bus.stage_2_to_3 = mk(12'd0, 1, 0, 0, 32'd1000, 32'd7, 32'd0, 0, 0, 1, 5'd4, 32'h1C000300);
        bus.valid_2 = 1'b1;
        @(negedge clk);
        bus.valid_2 = 1'b0;
        repeat (11) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (bus.valid_3 !== 1'b0 || bus.allow_3 !== 1'b1) begin errors++; $display("FAIL div_reset_abort: got valid=%b allow=%b want 0/1", bus.valid_3, bus.allow_3); end
        checks++; if (bus.rf_waddr_3_fwd !== 5'd0) begin errors++; $display("FAIL div_reset_fwd: got %0d want 0", bus.rf_waddr_3_fwd); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_div("div_after_reset", 1, 0, 32'd9, 32'd3, 32'd3);
        @(negedge clk);
    endtask
`else
    task automatic test_div_ignored();
        bus.allow_4 = 1'b1;
        bus.stage_2_to_3 = mk(onehot(ALU_ADD), 1, 1, 1, 32'd5, 32'd7, 32'd0, 0, 0, 1, 5'd2, 32'h1C000400);
        bus.valid_2 = 1'b1;
        @(negedge clk);
        bus.valid_2 = 1'b0;
        checks++; if (bus.valid_3 !== 1'b1) begin errors++; $display("FAIL nodiv_valid_3: got %b want 1", bus.valid_3); end
        checks++; if (bus.alu_result !== 32'd12) begin errors++; $display("FAIL nodiv_result: got %h want 0000000c", bus.alu_result); end
        checks++; if (bus.allow_3 !== 1'b1) begin errors++; $display("FAIL nodiv_allow_3: got %b want 1", bus.allow_3); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_store();
        test_load_stall();
        test_back_to_back();
`ifdef MYCPU_DIV_EN
        test_div();
        test_div_stall();
        test_div_reset();
`else
        test_div_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
